// File: rtl/key_scan.sv
// 4x4 keypad scanner: drives one row low at a time, classifies each full sweep,
// debounces presses and releases, and shifts accepted key codes into a hex register.
module key_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] data
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_N     = 4'(DEBOUNCE);

  logic [3:0]  col_m_q, col_m_d, col_s_q, col_s_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  r_q, r_d;
  logic [1:0]  acc_n_q, acc_n_d;
  logic [3:0]  acc_code_q, acc_code_d;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic [31:0] data_q, data_d;

  logic        div_last, sweep_done, accept;
  logic [1:0]  samp_n, samp_col, tot_n;
  logic [2:0]  sum_n;
  logic [3:0]  tot_code;

  assign row_n     = ~(4'b0001 << r_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign data      = data_q;

  assign div_last   = (div_q == DIV_LAST);
  assign sweep_done = div_last && (r_q == 2'd3);

  // Low-sample count saturates at 2: only EMPTY / SINGLE / MULTI matter.
  always_comb begin
    samp_n   = 2'd0;
    samp_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        samp_col = 2'(c);
        if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
      end
    end
    sum_n    = {1'b0, acc_n_q} + {1'b0, samp_n};
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n_q != 2'd0) ? acc_code_q : {r_q, samp_col};
  end

  always_comb begin
    col_m_d     = col_n;
    col_s_d     = col_m_q;
    div_d       = div_last ? 16'd0 : div_q + 16'd1;
    r_d         = div_last ? r_q + 2'd1 : r_q;
    acc_n_d     = acc_n_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    data_d      = data_q;
    accept      = 1'b0;

    if (div_last) begin
      if (r_q == 2'd3) begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_n_d    = tot_n;
        acc_code_d = tot_code;
      end
    end

    if (sweep_done) begin
      unique case (state_q)
        IDLE: if (tot_n == 2'd1) begin
          cand_d = tot_code;
          cnt_d  = 4'd1;
          if (DB_N == 4'd1) accept = 1'b1;
          else              state_d = PRESS_DB;
        end
        PRESS_DB: if (tot_n == 2'd1 && tot_code == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == DB_N) accept = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
        HELD: if (tot_n == 2'd0) begin
          if (DB_N == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = 4'd1;
          end
        end
        RELEASE_DB: if (tot_n == 2'd0) begin
          if (cnt_q + 4'd1 == DB_N) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = HELD;
          cnt_d   = 4'd0;
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = tot_code;
      data_d      = {data_q[27:0], tot_code};
      state_d     = HELD;
      cnt_d       = 4'd0;
    end

    // Clear beats a coincident acceptance; the pulse and code still go out.
    if (clr) data_d = 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m_q     <= 4'hF;
      col_s_q     <= 4'hF;
      div_q       <= 16'd0;
      r_q         <= 2'd0;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      data_q      <= 32'd0;
    end else begin
      col_m_q     <= col_m_d;
      col_s_q     <= col_s_d;
      div_q       <= div_d;
      r_q         <= r_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      data_q      <= data_d;
    end
  end

endmodule
